// File: rtl/mdu_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mdu_pkg: shared md_op encodings and MDU state type                      |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
package mdu_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int max_int(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_md_compute.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | md_compute: combinational multiply/divide result for the latched op     |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module md_compute
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next,
    output logic             div_by_zero
);

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [2*WIDTH-1:0] w_ext_a;
    logic [2*WIDTH-1:0] w_ext_b;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH-1:0]   w_den;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;

    always_comb begin
        w_signed = (op == MD_MULT) || (op == MD_DIV);
        w_neg_a  = w_signed & a[WIDTH-1];
        w_neg_b  = w_signed & b[WIDTH-1];

        w_ext_a  = {{WIDTH{w_neg_a}}, a};
        w_ext_b  = {{WIDTH{w_neg_b}}, b};
        w_prod   = w_ext_a * w_ext_b;

        // Magnitude divide; most-negative / -1 wraps back to most-negative with rem 0.
        w_mag_a  = w_neg_a ? -a : a;
        w_mag_b  = w_neg_b ? -b : b;
        w_den    = (w_mag_b == '0) ? WIDTH'(1) : w_mag_b;
        w_quot   = w_mag_a / w_den;
        w_rem    = w_mag_a % w_den;
        w_quot_s = (w_neg_a ^ w_neg_b) ? -w_quot : w_quot;
        w_rem_s  = w_neg_a ? -w_rem : w_rem;

        div_by_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (b == '0);

        hi_next = '0;
        lo_next = '0;
        case (op)
            MD_MULT, MD_MULTU: {hi_next, lo_next} = w_prod;
            MD_DIV, MD_DIVU: begin
                hi_next = w_rem_s;
                lo_next = w_quot_s;
            end
            default: begin
                hi_next = '0;
                lo_next = '0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mdu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | mdu: multi-cycle multiply/divide unit with architectural HI/LO          |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module mdu
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       md_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(max_int(MUL_CYCLES, DIV_CYCLES) + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic [WIDTH-1:0] w_hi_next;
    logic [WIDTH-1:0] w_lo_next;
    logic             w_div_by_zero;

    md_compute #(
        .WIDTH (WIDTH)
    ) u_md_compute (
        .op          (r_op),
        .a           (r_a),
        .b           (r_b),
        .hi_next     (w_hi_next),
        .lo_next     (w_lo_next),
        .div_by_zero (w_div_by_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_op    <= MD_NONE;
            r_a     <= '0;
            r_b     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU: begin
                                r_op    <= md_op;
                                r_a     <= a;
                                r_b     <= b;
                                r_cnt   <= CNT_W'(MUL_CYCLES);
                                r_state <= RUN;
                                busy    <= 1'b1;
                            end
                            MD_DIV, MD_DIVU: begin
                                r_op    <= md_op;
                                r_a     <= a;
                                r_b     <= b;
                                r_cnt   <= CNT_W'(DIV_CYCLES);
                                r_state <= RUN;
                                busy    <= 1'b1;
                            end
                            MD_MTHI: hi <= a;
                            MD_MTLO: lo <= a;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Requests arriving mid-operation are dropped, MTHI/MTLO included.
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= IDLE;
                        busy    <= 1'b0;
                        if (!w_div_by_zero) begin
                            hi <= w_hi_next;
                            lo <= w_lo_next;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mdu.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_mdu: directed, table-driven self-checking bench for mdu              |
// | Rev 1.0 - initial release                                               |
// +-------------------------------------------------------------------------+
module tb_mdu;
    import mdu_pkg::*;

    localparam int NV = 11;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;
    vec_t vecs[NV];

    mdu #(
        .WIDTH      (32),
        .MUL_CYCLES (5),
        .DIV_CYCLES (10)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the result edge.
    task automatic run_op(input string name, input logic [2:0] op,
                          input logic [31:0] av, input logic [31:0] bv,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit intrude, input logic [31:0] prev_hi);
        int n;
        bit busy_ok;
        n = (op == MD_MULT || op == MD_MULTU) ? 5 : 10;
        busy_ok = 1'b1;
        start = 1'b1; md_op = op; a = av; b = bv;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE; a = ~av; b = ~bv;
        for (int k = 0; k < n; k++) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (intrude) begin
                if (k == 1) begin start = 1'b1; md_op = MD_MTHI; a = 32'hDEADBEEF; end
                if (k == 2) begin md_op = MD_MULT; a = 32'h5; b = 32'h5; end
                if (k == 3) begin
                    start = 1'b0; md_op = MD_NONE;
                    chk({name, "_hi_mid"}, hi, prev_hi);
                end
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk({name, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        chk({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        chk({name, "_hi"}, hi, eh);
        chk({name, "_lo"}, lo, el);
    endtask

    task automatic single(input logic [2:0] op, input logic [31:0] av, input bit rst);
        start = 1'b1; md_op = op; a = av; reset = rst;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE; reset = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{MD_MULT,  32'h00000007, 32'hFFFFFFFB, 32'hFFFFFFFF, 32'hFFFFFFDD};
        vecs[6]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'h7FFFFFFF};
        vecs[8]  = '{MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9]  = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002};
        vecs[10] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};

        reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;

        single(MD_MTLO, 32'h22, 1'b0);
        chk("mtlo_lo", lo, 32'h22);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        single(MD_MTHI, 32'h11, 1'b0);
        chk("mthi_hi", hi, 32'h11);
        single(3'd7, 32'h55, 1'b0);
        chk("op7_hi", hi, 32'h11);
        chk("op7_lo", lo, 32'h22);
        chk("op7_busy", {31'd0, busy}, 32'd0);

        run_op("div0", MD_DIV, 32'h5, 32'h0, 32'h11, 32'h22, 1'b0, '0);

        for (int i = 0; i < NV; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, 1'b0, '0);

        run_op("intrude", MD_MULT, 32'h3, 32'h4, 32'h0, 32'hC, 1'b1, 32'h40000000);

        single(MD_MTHI, 32'hABCD, 1'b0);
        chk("mthi2_hi", hi, 32'hABCD);
        chk("mthi2_busy", {31'd0, busy}, 32'd0);

        // Reset during the third busy cycle of a divide.
        single(MD_DIV, 32'd100, 1'b0);
        b = 32'd7;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_hi", hi, 32'd0);
        chk("rstmid_lo", lo, 32'd0);
        repeat (12) @(posedge clk);
        @(negedge clk);
        chk("rstmid_late_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_late_hi", hi, 32'd0);
        chk("rstmid_late_lo", lo, 32'd0);

        // Reset wins over a simultaneous request.
        single(MD_MTHI, 32'h1234, 1'b1);
        chk("rstprio_hi", hi, 32'd0);
        b = 32'd4;
        single(MD_MULT, 32'd3, 1'b1);
        chk("rstprio_busy", {31'd0, busy}, 32'd0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("rstprio_lo", lo, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mdu.md
# mdu

Multi-cycle multiply/divide unit with architectural HI/LO registers. It is the parametrised successor to the single-cycle ALU and sits beside it in the EX stage. It accepts one signed or unsigned multiply/divide per request and holds `busy` for a fixed, parameterised latency. It writes the 2×WIDTH product, or the quotient/remainder, into HI/LO when done. The hazard unit stalls on `start | busy`.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MUL_CYCLES`, 5: busy cycles for MULT/MULTU; ≥1.
- `DIV_CYCLES`, 10: busy cycles for DIV/DIVU; ≥1.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `start` input 1: request strobe, sampled on rising edge.
- `md_op` input 3: operation, qualified by `start`.
- `a` input WIDTH: operand A (rs).
- `b` input WIDTH: operand B (rt).
- `busy` output 1: multiply/divide in flight.
- `hi` output WIDTH: HI register, registered.
- `lo` output WIDTH: LO register, registered.

## Operation
- Operation encodings for `md_op`:
  - NONE = 0
  - MULT = 1
  - MULTU = 2
  - DIV = 3
  - DIVU = 4
  - MTHI = 5
  - MTLO = 6
  - 7 is reserved and treated as NONE.
- States: IDLE, RUN. Down-counter `cnt`, wide enough for max(MUL_CYCLES, DIV_CYCLES).
- IDLE with `start` and op 1–4:
  - latch operands and op;
  - set `cnt` to the op's latency;
  - go to RUN.
- IDLE with `start` and MTHI/MTLO: `hi` or `lo` takes `a` at that edge. Stay in IDLE; `busy` stays 0.
- RUN: `cnt` decrements every edge. On the edge where `cnt` goes 1→0, write HI/LO and return to IDLE.
- `start` while in RUN is ignored entirely, including MTHI/MTLO. The pipeline guarantees no such request occurs; the bench checks HI/LO are unaffected if one does.
- MULT / MULTU: {hi, lo} = 2×WIDTH product of sign-extended / zero-extended operands.
- DIV: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
- DIVU: unsigned quotient and remainder.
- Divide by zero (b = 0): full DIV_CYCLES still elapse, and HI/LO keep their prior values.
- Signed overflow (a = most-negative, b = −1): lo = most-negative, hi = 0.
- Operands are captured at start. Changes on `a`/`b` during RUN have no effect.
- Reset at any time, including mid-RUN: state IDLE, `cnt` = 0, `busy` = 0, `hi` = 0, `lo` = 0. The in-flight result is discarded.

## Timing
- Reset values: `busy` 0, `hi` 0, `lo` 0.
- Multiply/divide latency, with the request accepted at edge t0:
  - `busy` = 1 after t0 for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES);
  - HI/LO update and `busy` falls at edge t0+N;
  - `busy` does not itself cover the acceptance cycle, so the hazard unit uses `start | busy`.
- Back-to-back is legal: a new `start` in the cycle after `busy` falls is accepted.
- MTHI/MTLO latency: `hi`/`lo` updated at the accepting edge. A read (MFHI/MFLO) in the next cycle sees the new value.
- `reset` takes priority over `start` at the same edge.
- No combinational path from inputs to `busy`, `hi` or `lo`.

## Structure
- Shared package `mdu_pkg` holds the `md_op` encodings (MD_NONE … MD_MTLO) and the state enum {IDLE, RUN}. The decoder imports it as well.
- One natural sub-module, `md_compute`: a purely combinational block that takes the latched op and operands and produces {hi_next, lo_next, div_by_zero}. It includes the sign handling and the overflow/zero cases.
- `mdu` owns the FSM, counter, operand latches and HI/LO registers.
- No pipelined multiplier is required. Latency is modelled by the counter.

## Test plan
- MULT signed: a = 0xFFFFFFFE (−2), b = 3, start at t0 → `busy` high 5 cycles; at t0+5 hi = 0xFFFFFFFF, lo = 0xFFFFFFFA, `busy` = 0.
- MULTU: a = 0xFFFFFFFF, b = 0xFFFFFFFF → after 5 cycles hi = 0xFFFFFFFE, lo = 0x00000001.
- DIV signed: a = −7, b = 2 → after 10 cycles lo = 0xFFFFFFFD (−3), hi = 0xFFFFFFFF (−1).
- DIVU: a = 7, b = 2 → lo = 3, hi = 1.
- DIV corner cases:
  - a = 0x80000000, b = −1 → lo = 0x80000000, hi = 0.
  - Divide by zero with prior hi = 0x11, lo = 0x22 → unchanged after 10 busy cycles.
- Control:
  - MTHI a = 0xABCD → `hi` = 0xABCD next cycle, `busy` never asserts.
  - Assert `reset` at cycle 3 of a DIV → `busy`, `hi`, `lo` all 0 next cycle, and no late write occurs.
  - `start` MULT during RUN → ignored; the original result lands on schedule.
